// File: rtl/digi_logic.sv
// rtl/digi_logic.sv - registered 4-bit code decoder: prime flag (out1) and divisible-by-3 flag (out2)
// Optional DIGI_LOGIC_VALID_EN adds in_vld/out_vld and loads the flags only on valid cycles.
module digi_logic (
   input  logic clk,
   input  logic rst,
   input  logic a,
   input  logic b,
   input  logic c,
   input  logic d,
`ifdef DIGI_LOGIC_VALID_EN
   input  logic in_vld,
   output logic out_vld,
`endif
   output logic out1,
   output logic out2
);

   logic [3:0] code;
   logic       prime;
   logic       div3;

   assign code = {a, b, c, d};

   always_comb begin
      prime = (~a & ~b & c) | (~a & b & d) | (~b & c & d) | (b & ~c & d);
      div3  = 1'b0;
      case (code)
         4'd0, 4'd3, 4'd6, 4'd9, 4'd12, 4'd15: div3 = 1'b1;
         default:                              div3 = 1'b0;
      endcase
   end

   // Reset wins over the decode, so code 0 during reset still reads 0/0.
   always_ff @(posedge clk) begin
      if (rst) begin
         out1 <= 1'b0;
         out2 <= 1'b0;
`ifdef DIGI_LOGIC_VALID_EN
         out_vld <= 1'b0;
`endif
      end else begin
`ifdef DIGI_LOGIC_VALID_EN
         out_vld <= in_vld;
         if (in_vld) begin
            out1 <= prime;
            out2 <= div3;
         end
`else
         out1 <= prime;
         out2 <= div3;
`endif
      end
   end

endmodule

// File: tb/tb_digi_logic.sv
// tb/tb_digi_logic.sv - scoreboard bench for digi_logic with a divisor-based reference model
module tb_digi_logic;

`ifdef DIGI_LOGIC_VALID_EN
   localparam bit VEN = 1'b1;
`else
   localparam bit VEN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
   logic out1, out2;
`ifdef DIGI_LOGIC_VALID_EN
   logic in_vld = 1'b0;
   logic out_vld;
`endif

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic o1;
      logic o2;
      logic v;
   } exp_t;

   exp_t exp_q[$];
   exp_t last_exp;
   bit   have_last = 1'b0;
   logic m1 = 1'b0, m2 = 1'b0;

   digi_logic dut (
      .clk(clk),
      .rst(rst),
      .a(a),
      .b(b),
      .c(c),
      .d(d),
`ifdef DIGI_LOGIC_VALID_EN
      .in_vld(in_vld),
      .out_vld(out_vld),
`endif
      .out1(out1),
      .out2(out2)
   );

   always #5 clk = ~clk;

   function automatic logic is_prime(input int n);
      if (n < 2) return 1'b0;
      for (int k = 2; k < n; k++)
         if (n % k == 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic check(input string name, input logic act, input logic want);
      checks++;
      if (act !== want) begin
         failures++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, want, $time);
      end
   endtask

   task automatic compare_all(input string tag, input exp_t e);
      check({tag, "_out1"}, out1, e.o1);
      check({tag, "_out2"}, out2, e.o2);
`ifdef DIGI_LOGIC_VALID_EN
      check({tag, "_out_vld"}, out_vld, e.v);
`endif
   endtask

   // Drive one cycle of stimulus and record what the outputs must show after the next edge.
   task automatic step(input logic r, input int n, input logic v);
      exp_t e;
      @(negedge clk);
      rst = r;
      {a, b, c, d} = 4'(n);
`ifdef DIGI_LOGIC_VALID_EN
      in_vld = v;
`endif
      if (r) begin
         m1 = 1'b0;
         m2 = 1'b0;
      end else if (v || !VEN) begin
         m1 = is_prime(n);
         m2 = (n % 3 == 0);
      end
      e.o1 = m1;
      e.o2 = m2;
      e.v  = r ? 1'b0 : v;
      exp_q.push_back(e);
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         compare_all("edge", e);
         last_exp  = e;
         have_last = 1'b1;
      end
   end

   // Outputs must not follow inputs that change between edges.
   always @(negedge clk) begin
      #2;
      if (have_last) compare_all("hold", last_exp);
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      logic r, v;
      step(1'b1, 0, 1'b1);
      step(1'b1, 0, 1'b1);
      for (int n = 0; n < 16; n++) step(1'b0, n, 1'b1);
      step(1'b0, 3, 1'b1);
      step(1'b0, 15, 1'b1);
      step(1'b0, 13, 1'b1);
      step(1'b0, 3, 1'b1);
      step(1'b1, 3, 1'b1);
      step(1'b0, 12, 1'b1);
      if (VEN) begin
         step(1'b0, 5, 1'b1);
         step(1'b0, 6, 1'b0);
         step(1'b0, 6, 1'b1);
      end
      for (int i = 0; i < 80; i++) begin
         r = ($urandom_range(0, 15) == 0);
         v = VEN ? 1'(($urandom_range(0, 3) != 0)) : 1'b1;
         step(r, $urandom_range(0, 15), v);
      end
      step(1'b0, 7, 1'b1);
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
